fifo_wr_arb_rr: RTL
===================

# fifo_wr_arb_rr

Round-robin write arbiter that shares one single-clock register-based FIFO write port among REQ_NUM requesters. Each requester has a valid/ready handshake. The winner's data is tagged with its requester index and forwarded to the FIFO write port in the same cycle. An optional burst lock keeps the grant on one requester for up to BURST_MAX consecutive beats. The block sits directly in front of the shared FIFO and is the only writer to it.

## Interface
- REQ_NUM, 4: number of requesters; must be ≥ 2.
- DATA_WD, 32: payload width per requester.
- BURST_MAX, 4: maximum beats per grant; 1 disables locking.
- ID_WD (localparam): FUNC_LOG2(REQ_NUM).
- CNT_WD (localparam): FUNC_LOG2(BURST_MAX)+1.

Reset rstn, asynchronous, active-low; clock clk.

- clk  input  1  clock.
- rstn  input  1  asynchronous active-low reset.
- req_val_i  input  REQ_NUM  per-requester valid.
- req_dat_i  input  REQ_NUM*DATA_WD  payloads; requester i occupies bits [i*DATA_WD +: DATA_WD].
- req_rdy_o  output  REQ_NUM  per-requester ready; one-hot or zero.
- fifo_wr_val_o  output  1  FIFO write strobe.
- fifo_wr_dat_o  output  ID_WD+DATA_WD  {winner index, winner payload}.
- fifo_wr_ful_i  input  1  FIFO full flag.
- stat_cnt_o  output  REQ_NUM*16  per-requester accepted-beat counters; see Configuration.

## Operation
- A transfer for requester i happens when req_val_i[i] && req_rdy_o[i].
- fifo_wr_val_o = OR of all transfers. A write is never issued while fifo_wr_ful_i=1.
- req_rdy_o[i] = grant[i] && !fifo_wr_ful_i. grant is combinational from state and req_val_i, so grant is zero when no valid is present.
- Requester protocol: once req_val_i[i] is raised, val and dat are held until the transfer. The arbiter does not check this.
- Registered state: st (IDLE/LOCK), ptr (ID_WD bits), owner (ID_WD bits), cnt (CNT_WD bits).
- IDLE:
  - Winner = first valid requester searching from ptr upward, wrapping from REQ_NUM-1 to 0.
  - On a transfer with BURST_MAX=1: ptr←winner+1 mod REQ_NUM; stay in IDLE.
  - On a transfer with BURST_MAX>1: go to LOCK; owner←winner; cnt←1.
- LOCK with req_val_i[owner]=1:
  - Only owner is granted.
  - On a transfer, cnt←cnt+1. If cnt+1 == BURST_MAX: go to IDLE; ptr←owner+1 mod REQ_NUM; cnt←0.
- LOCK with req_val_i[owner]=0:
  - The lock is released in this cycle and the cycle arbitrates exactly as IDLE, with the search starting from owner+1.
  - ptr←owner+1; st and cnt are then updated per the IDLE rules from this cycle's result.
- Full stall: while fifo_wr_ful_i=1, all registers hold. A pending lock survives the stall.
- Index wrap: ptr+1 and owner+1 wrap to 0 when REQ_NUM is not a power of two.

## Timing
- Zero-cycle latency: request to fifo_wr_val_o/fifo_wr_dat_o is combinational.
- State updates on the posedge after a transfer.
- Reset values: st=IDLE, ptr=0, owner=0, cnt=0, stat counters=0.
- With req_val_i=0 after reset, req_rdy_o=0, fifo_wr_val_o=0, fifo_wr_dat_o=0.
- fifo_wr_dat_o is 0 whenever fifo_wr_val_o=0.
- Sustained throughput is 1 beat/cycle while not full.
- fifo_wr_ful_i is taken as registered inside the FIFO, so no combinational loop exists.
- Reset mid-burst: the lock is aborted and the next grant follows IDLE rules from ptr=0.

## Configuration
- Macro FIFO_WR_ARB_STAT_EN.
- Defined: stat_cnt_o[i*16 +: 16] increments on each transfer of requester i and saturates at 16'hFFFF.
- Undefined: no counter registers are instantiated and stat_cnt_o is tied to 0.
- In both cases the port list is identical.

## Test plan
- BURST_MAX=1, req_val_i=4'b1111, not full, 8 cycles: grants 0,1,2,3,0,1,2,3; fifo_wr_dat_o[ID field]=0,1,2,3,…
- BURST_MAX=4, req_val_i=4'b0101 held: beats from requester 0 ×4, then requester 2 ×4, then 0 ×4; cnt returns to 0 at each switch.
- Requester 1 is locked at cnt=2 and drops val while requester 3 is valid: requester 3 is granted in the same cycle; ptr becomes 2 and then follows IDLE rules.
- fifo_wr_ful_i=1 for 3 cycles mid-burst, all valid:
  - req_rdy_o=0 and fifo_wr_val_o=0 for those cycles.
  - The burst then resumes with the same owner and unchanged cnt.
  - The FIFO's full-write check never fires.
- REQ_NUM=3, only requester 2 valid: ptr wraps to 0 after its burst.
- With FIFO_WR_ARB_STAT_EN, 100 beats from requester 0 and 37 from requester 3: stat_cnt_o shows 100, 0, 0, 37 for requesters 0–3. Asserting rstn low mid-run clears all counters and state.

Source files
------------

// File: rtl/fifo_wr_arb_rr.sv
// rtl/fifo_wr_arb_rr.sv - round-robin write arbiter with burst lock in front of a shared FIFO
//
// Ports:
//   clk, rstn      clock and asynchronous active-low reset
//   req_val_i      per-requester valid
//   req_dat_i      per-requester payload, requester i at [i*DATA_WD +: DATA_WD]
//   req_rdy_o      per-requester ready (one-hot or zero)
//   fifo_wr_val_o  FIFO write strobe
//   fifo_wr_dat_o  {winner index, winner payload}, zero when no write
//   fifo_wr_ful_i  FIFO full flag (registered inside the FIFO)
//   stat_cnt_o     per-requester accepted-beat counters, 16 bits each
//
// Optional feature: define FIFO_WR_ARB_STAT_EN to build the saturating
// per-requester beat counters; otherwise stat_cnt_o is tied to zero.

module fifo_wr_arb_rr #(
    parameter int REQ_NUM   = 4,
    parameter int DATA_WD   = 32,
    parameter int BURST_MAX = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [REQ_NUM-1:0]         req_val_i,
    input  logic [REQ_NUM*DATA_WD-1:0] req_dat_i,
    output logic [REQ_NUM-1:0]         req_rdy_o,
    output logic                       fifo_wr_val_o,
    output logic [$clog2(REQ_NUM)+DATA_WD-1:0] fifo_wr_dat_o,
    input  logic                       fifo_wr_ful_i,
    output logic [REQ_NUM*16-1:0]      stat_cnt_o
);

    localparam int ID_WD  = $clog2(REQ_NUM);
    localparam int CNT_WD = $clog2(BURST_MAX) + 1;

    typedef enum logic {
        ST_IDLE,
        ST_LOCK
    } st_t;

    st_t               st, st_nxt;
    logic [ID_WD-1:0]  ptr, ptr_nxt;
    logic [ID_WD-1:0]  owner, owner_nxt;
    logic [CNT_WD-1:0] cnt, cnt_nxt;

    logic               lock_hold;
    logic [ID_WD-1:0]   base;
    logic               srch_hit;
    logic [ID_WD-1:0]   srch_id;
    logic               win_hit;
    logic [ID_WD-1:0]   win_id;
    logic [REQ_NUM-1:0] grant;
    logic               xfer;

    // Index increment with wrap, also correct for non power-of-two REQ_NUM.
    function automatic logic [ID_WD-1:0] inc_wrap(input logic [ID_WD-1:0] v);
        if (int'(v) == REQ_NUM - 1) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    // Arbitration. A lock whose owner has dropped valid is released in the
    // same cycle, and that cycle is arbitrated as IDLE starting at owner+1.
    always_comb begin : arb
        int idx;
        idx       = 0;
        lock_hold = (st == ST_LOCK) && req_val_i[owner];
        base      = (st == ST_LOCK) ? inc_wrap(owner) : ptr;
        srch_hit  = 1'b0;
        srch_id   = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            idx = (int'(base) + k) % REQ_NUM;
            if (!srch_hit && req_val_i[idx]) begin
                srch_hit = 1'b1;
                srch_id  = ID_WD'(idx);
            end
        end
        win_hit = lock_hold || srch_hit;
        win_id  = lock_hold ? owner : srch_id;
        grant   = '0;
        if (win_hit) begin
            grant[win_id] = 1'b1;
        end
    end

    assign xfer          = win_hit && !fifo_wr_ful_i;
    assign req_rdy_o     = fifo_wr_ful_i ? '0 : grant;
    assign fifo_wr_val_o = xfer;
    assign fifo_wr_dat_o = xfer ? {win_id, req_dat_i[win_id*DATA_WD +: DATA_WD]} : '0;

    // Next state. Everything holds while the FIFO is full, so a pending lock
    // survives the stall untouched.
    always_comb begin
        st_nxt    = st;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        if (!fifo_wr_ful_i) begin
            if (lock_hold) begin
                if (int'(cnt) + 1 == BURST_MAX) begin
                    st_nxt  = ST_IDLE;
                    ptr_nxt = inc_wrap(owner);
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else begin
                ptr_nxt = base;
                st_nxt  = ST_IDLE;
                cnt_nxt = '0;
                if (srch_hit) begin
                    if (BURST_MAX == 1) begin
                        ptr_nxt = inc_wrap(srch_id);
                    end else begin
                        st_nxt    = ST_LOCK;
                        owner_nxt = srch_id;
                        cnt_nxt   = CNT_WD'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st    <= ST_IDLE;
            ptr   <= '0;
            owner <= '0;
            cnt   <= '0;
        end else begin
            st    <= st_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef FIFO_WR_ARB_STAT_EN
    logic [15:0] stat_q [REQ_NUM];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < REQ_NUM; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REQ_NUM; i++) begin
                if (xfer && grant[i] && stat_q[i] != 16'hFFFF) begin
                    stat_q[i] <= stat_q[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < REQ_NUM; g++) begin : g_stat
        assign stat_cnt_o[g*16 +: 16] = stat_q[g];
    end
`else
    assign stat_cnt_o = '0;
`endif

endmodule
